// File: rtl/program_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream, writes DATA_W-bit words
// into memory from address 0, checks an XOR checksum, and keeps the CPU in reset until the load succeeds.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BYTES = DATA_W / 8;
  localparam logic [7:0]  LAST_BYTE = 8'(BYTES - 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t state, next_state;

  logic [7:0]          len_hi;
  logic [7:0]          chk;
  logic [7:0]          byte_idx;
  logic [15:0]         remaining;
  logic [ADDR_W-1:0]   index;
  logic [DATA_W-1:0]   word;

  logic                accept;
  logic                can_start;
  logic                last_byte;
  logic [15:0]         len_full;
  logic [DATA_W+7:0]   shifted;
  logic [DATA_W-1:0]   word_next;

  assign accept    = in_valid && in_ready;
  assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign last_byte = (byte_idx == LAST_BYTE);
  assign len_full  = {len_hi, in_data};
  assign shifted   = {word, in_data};
  assign word_next = shifted[DATA_W-1:0];

  // Status outputs are pure decodes of the registered state, so they never glitch on inputs.
  assign in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CHECK);
  assign busy      = in_ready;
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);
  assign cpu_reset = (state != S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) next_state = S_LEN_HI;
      S_LEN_HI: if (accept) next_state = S_LEN_LO;
      S_LEN_LO: if (accept) begin
        if (len_full == 16'd0)                 next_state = S_CHECK;
        else if ({1'b0, len_full} > MAX_WORDS) next_state = S_ERROR;
        else                                   next_state = S_DATA;
      end
      S_DATA:   if (accept && last_byte && remaining == 16'd1) next_state = S_CHECK;
      S_CHECK:  if (accept) next_state = (in_data == chk) ? S_DONE : S_ERROR;
      default:  next_state = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset synchronously; there is no storage array here to exempt.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi    <= '0;
      chk       <= '0;
      byte_idx  <= '0;
      remaining <= '0;
      index     <= '0;
      word      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (can_start && start) begin
        chk      <= '0;
        byte_idx <= '0;
        index    <= '0;
      end
      if (accept) begin
        unique case (state)
          S_LEN_HI: len_hi    <= in_data;
          S_LEN_LO: remaining <= len_full;
          S_DATA: begin
            chk  <= chk ^ in_data;
            word <= word_next;
            if (last_byte) begin
              byte_idx  <= '0;
              mem_we    <= 1'b1;
              mem_addr  <= index;
              mem_wdata <= word_next;
              index     <= index + 1'b1;
              remaining <= remaining - 16'd1;
            end else begin
              byte_idx <= byte_idx + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised self-checking bench for program_loader; a stream-level reference model
// predicts the memory writes and the final done/error outcome of each load.
module tb_program_loader;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [23:0] wr_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_reset, busy, done, error;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  int checks = 0;
  int failures = 0;
  wr_q_t seen;

  program_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) seen.push_back({mem_addr, mem_wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: parse the stream as the loader's byte format defines it.
  function automatic void model(input byte_q_t s, output wr_q_t w, output bit exp_done);
    int n;
    logic [7:0] x;
    w = {};
    n = {s[0], s[1]};
    x = 8'h00;
    exp_done = 1'b0;
    if (n > 256) return;
    for (int i = 0; i < n; i++) begin
      w.push_back({8'(i), s[2 + 2*i], s[3 + 2*i]});
      x = x ^ s[2 + 2*i] ^ s[3 + 2*i];
    end
    exp_done = (s[2 + 2*n] == x);
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int n = 0;
    repeat (gap) begin @(negedge clk); in_valid = 1'b0; start = 1'b0; end
    @(negedge clk);
    in_valid = 1'b1; in_data = b; start = with_start;
    while (!in_ready && n < 50) begin @(negedge clk); start = 1'b0; n++; end
    check("ready_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
  endtask

  task automatic run_load(input string tag, input byte_q_t s, input bit gaps, input int start_at);
    wr_q_t exp_w;
    bit exp_done;
    int n = 0;
    model(s, exp_w, exp_done);
    seen.delete();
    pulse_start();
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_cpurst_after_start"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done_cleared"}, 32'(done), 32'd0);
    foreach (s[i]) send_byte(s[i], gaps ? int'($urandom_range(0, 3)) : 0, i == start_at);
    @(negedge clk); in_valid = 1'b0; start = 1'b0;
    while (!(done || error) && n < 20) begin @(negedge clk); n++; end
    check({tag, "_result_timeout"}, 32'(n < 20), 32'd1);
    repeat (2) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(!exp_done));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_write_count"}, 32'(seen.size()), 32'(exp_w.size()));
    foreach (exp_w[i]) if (i < seen.size()) check({tag, "_write"}, 32'(seen[i]), 32'(exp_w[i]));
  endtask

  initial begin
    byte_q_t s;
    int nw;
    bit corrupt;
    logic [7:0] x;

    // Reset held two cycles.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load("good2", s, 1'b0, -1);
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_load("badchk", s, 1'b0, -1);
    s = '{8'h01, 8'h01};
    run_load("toolong", s, 1'b0, -1);
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load("gaps_midstart", s, 1'b1, 4);

    // Reset after the first word is written, then reload.
    pulse_start();
    send_byte(8'h00, 0, 1'b0); send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0); send_byte(8'h34, 0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("abort_we", 32'(mem_we), 32'd1);
    check("abort_word0", 32'({mem_addr, mem_wdata}), 32'h00_1234);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load("reload", s, 1'b0, -1);
    s = '{8'h00, 8'h00, 8'h00};
    run_load("empty", s, 1'b0, -1);

    // Random short programs, some with corrupted checksums.
    for (int k = 0; k < 5; k++) begin
      nw = $urandom_range(1, 6);
      corrupt = 1'($urandom_range(0, 1));
      s = '{8'h00, 8'(nw)};
      x = 8'h00;
      for (int i = 0; i < 2 * nw; i++) begin
        s.push_back(8'($urandom));
        x = x ^ s[s.size() - 1];
      end
      s.push_back(corrupt ? ~x : x);
      run_load("random", s, 1'b1, -1);
    end

    // Maximum-length program: last write lands on address 0xFF.
    s = '{8'h01, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 512; i++) begin
      s.push_back(8'($urandom));
      x = x ^ s[s.size() - 1];
    end
    s.push_back(x);
    run_load("full256", s, 1'b0, -1);
    if (seen.size() > 0) check("full256_last_addr", 32'(seen[seen.size() - 1][23:16]), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
